frame_buffer_controller: RTL
============================

// Module: frame_buffer_controller
//
// PURPOSE
//   Owns the two framebuffers and decides which one is scanned out (front) and which one is rendered into (back).
//   Sits between the renderer and the video/buffer datapath, in the master clock domain.
//   Grants the back buffer to the renderer and defers the front/back swap to the next vsync.
//   Publishes lock and vsync state for the status path, plus frame and dropped-frame counters.
//
// PARAMETERS
//   CNT_WIDTH   8   width of o_frame_count and o_dropped_count
//
// PORTS
//   i_master_clk     in   1          master clock
//   i_reset          in   1          asynchronous, active-high reset
//   i_video_vsync_n  in   1          vsync from the pixel clock domain, active-low, asynchronous to i_master_clk
//   i_lock_request   in   1          renderer requests the back buffer (level, sampled per cycle)
//   i_render_done    in   1          1-cycle pulse: rendering finished, request a swap
//   i_abort          in   1          1-cycle pulse: release the lock without swapping
//   o_lock_grant     out  1          1-cycle pulse: back buffer granted
//   o_buffer_locked  out  1          renderer currently holds the back buffer (state LOCKED)
//   o_swap_pending   out  1          swap requested, waiting for vsync (state PENDING)
//   o_front_buffer   out  1          index of the buffer being scanned out
//   o_back_buffer    out  1          always equal to ~o_front_buffer
//   o_vsync_event    out  1          1-cycle pulse per synchronized vsync
//   o_frame_count    out  CNT_WIDTH  number of completed swaps; wraps modulo 2^CNT_WIDTH
//   o_dropped_count  out  CNT_WIDTH  vsyncs seen in state LOCKED; saturates at all-ones
//
// BEHAVIOUR
//   Reset values
//     - State IDLE; o_front_buffer=0, o_back_buffer=1.
//     - All other outputs 0; counters 0.
//     - Synchronizer flops cleared to 3'b000.
//     - Reset asserted mid-operation drops any lock or pending swap immediately.
//   Vsync synchronizer
//     - 3-flop shift register of ~i_video_vsync_n.
//     - Event when stage[2]==0 && stage[1]==1, i.e. on the vsync assertion edge.
//     - o_vsync_event is registered and pulses 3 clocks after the input edge.
//     - Vsync held asserted produces exactly one event.
//   State machine (registered; all outputs registered)
//     IDLE:
//       - i_lock_request=1 -> LOCKED; o_lock_grant pulses in the same cycle o_buffer_locked rises.
//     LOCKED:
//       - i_abort=1 -> IDLE with no swap. Abort wins over a simultaneous i_render_done.
//       - i_render_done=1 -> PENDING.
//       - Any vsync event seen in LOCKED increments o_dropped_count, including one coincident with render_done.
//     PENDING:
//       - On a vsync event: toggle front/back, o_frame_count+1, -> IDLE.
//       - i_lock_request, i_render_done and i_abort are ignored in PENDING.
//   Rules at boundaries
//     - Vsync in IDLE: no swap, no count change.
//     - Lock request coincident with a vsync in IDLE: grant taken, no drop counted.
//     - render_done or abort outside LOCKED: ignored.
//     - A swap never occurs in the same cycle that PENDING is entered; it waits for the next event.
//     - After the swap, IDLE lasts at least 1 cycle before a new grant, even if i_lock_request is held.
//     - o_frame_count wraps 0xFF -> 0x00 (CNT_WIDTH=8).
//     - o_dropped_count holds at 0xFF.
//
// STRUCTURE
//   Shared package:
//     - State encodings ST_IDLE=2'd0, ST_LOCKED=2'd1, ST_PENDING=2'd2. 2'd3 is illegal and recovers to IDLE.
//     - Buffer index constants BUF_A=1'b0, BUF_B=1'b1.
//   Sub-module vsync_edge_sync: 3-flop synchronizer plus edge detect with an async reset.
//     Reused by any block that needs a master-domain vsync pulse.
//
// TESTING
//   1. Reset, then hold vsync_n=1 for 10 cycles.
//        -> front=0, back=1, all flags and counters 0, no grant.
//   2. Lock request in IDLE.
//        -> grant pulse 1 cycle wide, locked=1.
//      Then render_done, then a vsync_n falling edge.
//        -> event 3 cycles later; front=1, frame_count=1, state IDLE.
//   3. Lock, then two vsyncs before render_done.
//        -> dropped_count=2, no swap.
//      render_done, then a third vsync.
//        -> swap, frame_count=1.
//   4. Lock, then abort and render_done in the same cycle.
//        -> IDLE, front unchanged, swap_pending=0.
//      A following vsync.
//        -> no swap.
//   5. Preload 255 swaps, then one more swap.
//        -> frame_count=0x00.
//      Force 300 dropped vsyncs.
//        -> dropped_count=0xFF.
//   6. Assert i_reset while PENDING, then vsync.
//        -> front=0, state IDLE, no swap, counters 0.
//      Hold vsync_n low for 100 cycles.
//        -> exactly one o_vsync_event.

Source files
------------

// File: rtl/frame_buffer_controller_pkg.sv
// Shared definitions for the double-buffered framebuffer controller:
// FSM state encodings and buffer index constants.
package frame_buffer_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_PENDING = 2'd2
  } fbc_state_e;

  localparam logic BUF_A = 1'b0;
  localparam logic BUF_B = 1'b1;

endpackage

// File: rtl/frame_buffer_controller_vsync_edge_sync.sv
// Brings an active-low, asynchronous vsync into the local clock domain and
// emits one registered pulse per vsync assertion edge.
module vsync_edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_vsync_n,
  output logic o_vsync_event
);

  logic [2:0] stage_q;
  logic       event_q;

  // stage_q[0] may go metastable; the edge is judged only on the settled stages.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stage_q <= 3'b000;
      event_q <= 1'b0;
    end else begin
      stage_q <= {stage_q[1:0], ~i_vsync_n};
      event_q <= ~stage_q[2] & stage_q[1];
    end
  end

  assign o_vsync_event = event_q;

endmodule

// File: rtl/frame_buffer_controller.sv
// Front/back framebuffer ownership: grants the back buffer to the renderer and
// defers the swap to the next vsync, with frame and dropped-frame counters.
module frame_buffer_controller
  import frame_buffer_controller_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_master_clk,
  input  logic                 i_reset,
  input  logic                 i_video_vsync_n,
  input  logic                 i_lock_request,
  input  logic                 i_render_done,
  input  logic                 i_abort,
  output logic                 o_lock_grant,
  output logic                 o_buffer_locked,
  output logic                 o_swap_pending,
  output logic                 o_front_buffer,
  output logic                 o_back_buffer,
  output logic                 o_vsync_event,
  output logic [CNT_WIDTH-1:0] o_frame_count,
  output logic [CNT_WIDTH-1:0] o_dropped_count
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  fbc_state_e           state_q, state_d;
  logic                 front_q, front_d;
  logic                 grant_q, grant_d;
  logic [CNT_WIDTH-1:0] frame_q, frame_d;
  logic [CNT_WIDTH-1:0] dropped_q, dropped_d;
  logic                 vsync_evt;

  vsync_edge_sync u_vsync_sync (
    .i_clk         (i_master_clk),
    .i_reset       (i_reset),
    .i_vsync_n     (i_video_vsync_n),
    .o_vsync_event (vsync_evt)
  );

  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      front_q   <= BUF_A;
      grant_q   <= 1'b0;
      frame_q   <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      front_q   <= front_d;
      grant_q   <= grant_d;
      frame_q   <= frame_d;
      dropped_q <= dropped_d;
    end
  end

  // The FSM reacts to the already-registered vsync pulse, so a swap always
  // lands one cycle after o_vsync_event is visible.
  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    grant_d   = 1'b0;
    frame_d   = frame_q;
    dropped_d = dropped_q;
    case (state_q)
      ST_IDLE: begin
        if (i_lock_request) begin
          state_d = ST_LOCKED;
          grant_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (vsync_evt && (dropped_q != '1)) begin
          dropped_d = dropped_q + CntOne;
        end
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (i_render_done) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (vsync_evt) begin
          front_d = ~front_q;
          frame_d = frame_q + CntOne;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_lock_grant    = grant_q;
  assign o_buffer_locked = (state_q == ST_LOCKED);
  assign o_swap_pending  = (state_q == ST_PENDING);
  assign o_front_buffer  = front_q;
  assign o_back_buffer   = ~front_q;
  assign o_vsync_event   = vsync_evt;
  assign o_frame_count   = frame_q;
  assign o_dropped_count = dropped_q;

endmodule
